// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and types for the data-memory stage.
package y86_pkg;

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OP_NOP, OP_RD, OP_WR} op_t;

    // Map an instruction code to the kind of memory access it needs.
    function automatic op_t decode_op(input logic [3:0] icode);
        case (icode)
            I_MRMOVQ, I_RET, I_POPQ:   decode_op = OP_RD;
            I_RMMOVQ, I_CALL, I_PUSHQ: decode_op = OP_WR;
            default:                   decode_op = OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/y86_dmem_array.sv
// Single-port synchronous RAM, 64-bit words, registered read.
// Contents are deliberately not reset so a vendor macro can drop in.
module y86_dmem_array #(
    parameter  int DEPTH_WORDS = 16384,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH_WORDS];

    // Read-first port: rdata reflects the word before any same-edge write.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        rdata <= mem[idx];
    end

endmodule

// File: rtl/y86_dmem_ctrl.sv
// Y86-64 data-memory stage: valid/ready request, LATENCY wait cycles,
// one-cycle response pulse with held valM / mem_error.
module y86_dmem_ctrl
    import y86_pkg::*;
#(
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 1,
    parameter int CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        resp_valid,
    output logic [63:0] valM,
    output logic        mem_error,
    output logic        busy
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [63:0] BYTES = 64'(DEPTH_WORDS) << 3;

    state_t        state, state_nx;
    op_t           in_op, op_q;
    logic [63:0]   in_addr, in_wdata, wdata_q, rdata, resp_data, valm_q;
    logic          in_err, err_q, merr_q, ram_we;
    logic [AW-1:0] idx_q, ram_idx;
    logic [3:0]    cnt;

    // Request decode: pick address/data sources and classify errors.
    always_comb begin
        in_op    = decode_op(icode);
        in_addr  = valE;
        in_wdata = valA;
        case (icode)
            I_RET, I_POPQ: in_addr  = valA;
            I_CALL:        in_wdata = valP;
            default:       ;
        endcase
        in_err = (in_op != OP_NOP) &&
                 ((in_addr >= BYTES) || ((CHECK_ALIGN != 0) && (in_addr[2:0] != 3'b000)));
    end

    // FSM next state.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Latch the request on accept, count wait cycles, capture the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_NOP;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
            valm_q  <= '0;
            merr_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_q    <= in_op;
                    idx_q   <= in_addr[AW+2:3];
                    wdata_q <= in_wdata;
                    err_q   <= in_err;
                    cnt     <= 4'(LATENCY);
                end
                WAIT: cnt <= cnt - 4'd1;
                RESP: begin
                    valm_q <= resp_data;
                    merr_q <= err_q;
                end
                default: ;
            endcase
        end
    end

    // The RAM is addressed from the live request while idle so its registered
    // read is ready by the RESP cycle even when LATENCY is 0.
    assign ram_idx   = (state == IDLE) ? in_addr[AW+2:3] : idx_q;
    assign ram_we    = (state == RESP) && (op_q == OP_WR) && !err_q;
    assign resp_data = ((op_q == OP_RD) && !err_q) ? rdata : 64'd0;

    y86_dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    // Response is presented during the RESP pulse and held afterwards.
    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP);
    assign valM       = resp_valid ? resp_data : valm_q;
    assign mem_error  = resp_valid ? err_q : merr_q;

endmodule

// File: tb/tb_y86_dmem_ctrl.sv
// Directed bench: instance 0 has LATENCY=2 with alignment checks,
// instance 1 has LATENCY=0 with alignment ignored.
module tb_y86_dmem_ctrl;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [3:0]  icode [2];
    logic [63:0] valE [2];
    logic [63:0] valA [2];
    logic [63:0] valP [2];
    logic        resp_valid [2];
    logic [63:0] valM [2];
    logic        mem_error [2];
    logic        busy [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    y86_dmem_ctrl #(.DEPTH_WORDS(16384), .LATENCY(2), .CHECK_ALIGN(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .icode(icode[0]), .valE(valE[0]), .valA(valA[0]), .valP(valP[0]),
        .resp_valid(resp_valid[0]), .valM(valM[0]), .mem_error(mem_error[0]), .busy(busy[0])
    );

    y86_dmem_ctrl #(.DEPTH_WORDS(16384), .LATENCY(0), .CHECK_ALIGN(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .icode(icode[1]), .valE(valE[1]), .valA(valA[1]), .valP(valP[1]),
        .resp_valid(resp_valid[1]), .valM(valM[1]), .mem_error(mem_error[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request, return cycles from accept edge to the resp_valid
    // cycle, then valM/mem_error sampled one cycle after the pulse.
    task automatic txn(input int s, input logic [3:0] ic, input logic [63:0] e,
                       input logic [63:0] a, input logic [63:0] p,
                       output logic [63:0] m, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid[s] = 1'b1; icode[s] = ic; valE[s] = e; valA[s] = a; valP[s] = p;
        n = 0;
        while (!req_ready[s] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        icode[s] = 4'($urandom);
        valE[s]  = {$urandom, $urandom};
        valA[s]  = {$urandom, $urandom};
        valP[s]  = {$urandom, $urandom};
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_valid[s] && lat < 40);
        @(negedge clk);
        m  = valM[s];
        er = mem_error[s];
    endtask

    task automatic run(input string tag, input int s, input logic [3:0] ic,
                       input logic [63:0] e, input logic [63:0] a, input logic [63:0] p,
                       input logic [63:0] exp_m, input logic exp_er, input int exp_lat);
        logic [63:0] m;
        logic        er;
        int          lat;
        txn(s, ic, e, a, p, m, er, lat);
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".valM"}, m, exp_m);
        chk({tag, ".err"}, {63'd0, er}, {63'd0, exp_er});
        chk({tag, ".pulse"}, {63'd0, resp_valid[s]}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; icode[i] = 4'h0;
            valE[i] = '0; valA[i] = '0; valP[i] = '0;
        end
        rst_n = 1'b0;
        #12;
        chk("rst.ready", {63'd0, req_ready[0]}, 64'd1);
        chk("rst.resp",  {63'd0, resp_valid[0]}, 64'd0);
        chk("rst.busy",  {63'd0, busy[0]}, 64'd0);
        chk("rst.valM",  valM[0], 64'd0);
        chk("rst.err",   {63'd0, mem_error[0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // LATENCY=2 instance: response 3 cycles after accept
        run("wr0",    0, I_RMMOVQ, 64'h0,     64'h5A5A,     64'h0,  64'h0,        1'b0, 3);
        run("push",   0, I_PUSHQ,  64'h100,   64'hDEADBEEF, 64'h0,  64'h0,        1'b0, 3);
        run("pop",    0, I_POPQ,   64'h0,     64'h100,      64'h0,  64'hDEADBEEF, 1'b0, 3);
        run("rd_oor", 0, I_MRMOVQ, 64'h20000, 64'h0,        64'h0,  64'h0,        1'b1, 3);
        run("wr_oor", 0, I_RMMOVQ, 64'h20000, 64'hBAD,      64'h0,  64'h0,        1'b1, 3);
        run("rd0",    0, I_MRMOVQ, 64'h0,     64'h0,        64'h0,  64'h5A5A,     1'b0, 3);
        run("wr_mis", 0, I_RMMOVQ, 64'h103,   64'h77,       64'h0,  64'h0,        1'b1, 3);
        run("rd100",  0, I_MRMOVQ, 64'h100,   64'h0,        64'h0,  64'hDEADBEEF, 1'b0, 3);
        run("call",   0, I_CALL,   64'h1F8,   64'h999,      64'h42, 64'h0,        1'b0, 3);
        run("ret",    0, I_RET,    64'hFFFF,  64'h1F8,      64'h0,  64'h42,       1'b0, 3);
        run("nop",    0, 4'h0,     64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 64'h0, 64'h0,  1'b0, 3);

        // LATENCY=0, alignment ignored: 0x103 lands in word 0x20
        run("b_wr",   1, I_RMMOVQ, 64'h103,   64'h1234,     64'h0,  64'h0,        1'b0, 1);
        run("b_rd",   1, I_MRMOVQ, 64'h100,   64'h0,        64'h0,  64'h1234,     1'b0, 1);
        run("b_pop",  1, I_POPQ,   64'h0,     64'h107,      64'h0,  64'h1234,     1'b0, 1);

        // Continuous request at LATENCY=0: ready toggles, one response per 2 cycles
        @(negedge clk);
        req_valid[1] = 1'b1; icode[1] = I_MRMOVQ; valE[1] = 64'h100;
        for (int i = 0; i < 6; i++) begin
            chk("hs.ready", {63'd0, req_ready[1]},  64'((i % 2) == 0));
            chk("hs.resp",  {63'd0, resp_valid[1]}, 64'((i % 2) == 1));
            chk("hs.busy",  {63'd0, busy[1]},       64'((i % 2) == 1));
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        @(negedge clk);

        // Reset while a write is waiting aborts it
        run("pre_wr", 0, I_RMMOVQ, 64'h80, 64'h1111, 64'h0, 64'h0,    1'b0, 3);
        run("pre_rd", 0, I_MRMOVQ, 64'h80, 64'h0,    64'h0, 64'h1111, 1'b0, 3);
        @(negedge clk);
        req_valid[0] = 1'b1; icode[0] = I_RMMOVQ; valE[0] = 64'h80; valA[0] = 64'h2222;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("mid.busy", {63'd0, busy[0]}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar.ready", {63'd0, req_ready[0]},  64'd1);
        chk("ar.resp",  {63'd0, resp_valid[0]}, 64'd0);
        chk("ar.busy",  {63'd0, busy[0]},       64'd0);
        chk("ar.valM",  valM[0], 64'd0);
        chk("ar.err",   {63'd0, mem_error[0]},  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rd", 0, I_MRMOVQ, 64'h80, 64'h0, 64'h0, 64'h1111, 1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/y86_dmem_ctrl.md
Name: y86_dmem_ctrl

Overview:
Parametrised data-memory stage for the pipelined Y86-64 core; successor to the single-cycle SEQ memory stage.
- Decodes icode to a read or write of one 64-bit word.
- Uses a valid/ready request handshake, configurable wait-state latency and a registered response.
- Adds address range/alignment checking and a busy indication for the pipeline stall logic.
- Sits between the execute/memory pipeline register and the write-back register.

Parameters:
DEPTH_WORDS, 16384, number of 64-bit words; byte space is DEPTH_WORDS*8; must be a power of two.
LATENCY, 1, wait cycles between request accept and response (0..15).
CHECK_ALIGN, 1, when 1 an address with addr[2:0]!=0 is an error; when 0 the low 3 bits are ignored.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
icode  in  4  Y86 instruction code of request
valE  in  64  ALU result / address
valA  in  64  register A value (data or stack address)
valP  in  64  next PC (return address for call)
resp_valid  out  1  one-cycle pulse: response valid
valM  out  64  read data, held until next response
mem_error  out  1  address error for this response, held with valM
busy  out  1  transaction in flight (to stall logic)

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; resp_valid=0; valM=0; mem_error=0; busy=0. Memory array contents are not reset. Reset mid-transaction aborts it; no write occurs if the write had not yet been committed.
- Decode table:
  - read ops: 5 mrmovq (addr=valE), 9 ret (addr=valA), B popq (addr=valA).
  - write ops: 4 rmmovq (addr=valE, data=valA), 8 call (addr=valE, data=valP), A pushq (addr=valE, data=valA).
  - any other icode is a NOP op: no memory access, valM=0, mem_error=0.
- Accept: handshake fires on req_valid && req_ready. On accept the block latches op, addr, wdata and computes err.
  - err = (addr >= DEPTH_WORDS*8, unsigned 64-bit compare) || (CHECK_ALIGN && addr[2:0]!=0).
  - word index = addr[log2(DEPTH_WORDS)+2:3].
- FSM states:
  - IDLE: req_ready=1, busy=0. On accept go to WAIT, or to RESP if LATENCY==0; counter loads LATENCY.
  - WAIT: req_ready=0, busy=1; counter decrements each cycle; go to RESP when the counter reaches 1.
  - RESP: for one cycle resp_valid=1, busy=1, req_ready=0.
    - read: valM <= mem[idx].
    - write: mem[idx] <= wdata, committed on the RESP clock edge; valM <= 0.
    - NOP: valM <= 0.
    - mem_error <= err. If err=1 there is no write and valM <= 0.
    - Next state IDLE.
- Response timing: resp_valid asserts exactly LATENCY+1 cycles after the accept edge. Back-to-back throughput is one transaction per LATENCY+2 cycles.
- valM and mem_error are registered and hold their values until the next RESP.
- Read-after-write: a read accepted after a write's RESP cycle returns the new data; no forwarding is needed because requests serialise.
- Request inputs are ignored outside the accept cycle and may change freely.

Decomposition:
- Shared package y86_pkg: icode constants (I_RMMOVQ=4, I_MRMOVQ=5, I_CALL=8, I_RET=9, I_PUSHQ=A, I_POPQ=B), FSM state enum {IDLE, WAIT, RESP}, op enum {OP_NOP, OP_RD, OP_WR}.
- One sub-module, y86_dmem_array: single-port synchronous RAM, DEPTH_WORDS x 64, with we, idx, wdata, rdata. Registered read. Replaceable by a vendor macro.

Test Plan:
- Write then read at LATENCY=2: pushq valE=0x100 valA=0xDEADBEEF; then popq valA=0x100. Each resp_valid occurs 3 cycles after accept; the second response gives valM=0xDEADBEEF, mem_error=0.
- Range error: mrmovq valE=16384*8 gives mem_error=1 and valM=0. rmmovq at the same address leaves no write, checked by a readback of word 0 (unchanged).
- Alignment: rmmovq valE=0x103 with CHECK_ALIGN=1 gives mem_error=1. With CHECK_ALIGN=0 it writes word 0x20, and a readback at 0x100 matches.
- Call/ret pair: call valE=0x1F8 valP=0x42, then ret valA=0x1F8 gives valM=0x42. Also a NOP icode=0 gives resp_valid with valM=0, mem_error=0.
- Handshake: hold req_valid=1 continuously at LATENCY=0. req_ready toggles 1,0 and one response occurs per 2 cycles. busy=1 exactly while not IDLE.
- Reset mid-op: assert rst_n=0 in WAIT of a write to 0x80. All outputs go to 0 immediately (asynchronously), and a later read of 0x80 returns the prior value.
